// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the RAM responder: bus widths, FSM states
// and a helper that expands byte selects into a bit mask.
package wb_pkg;

   localparam int WB_DW   = 32;
   localparam int WB_AW   = 32;
   localparam int WB_SELW = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } wb_state_t;

   function automatic logic [WB_DW-1:0] sel_to_mask(input logic [WB_SELW-1:0] sel);
      logic [WB_DW-1:0] mask;
      mask = '0;
      for (int b = 0; b < WB_SELW; b++) begin
         mask[8*b +: 8] = {8{sel[b]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/wb_ram_array.sv
// Single-port synchronous RAM, 2^DEPTH_LOG2 x 32, with per-byte write enable
// and a registered read port that only updates when re_i is high.
module wb_ram_array
   import wb_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [WB_DW-1:0]      wmask_i,
   input  logic [WB_DW-1:0]      wdata_i,
   output logic [WB_DW-1:0]      rdata_o
);

   // One byte-wide memory per lane keeps each lane a plain block-RAM column.
   generate
      for (genvar gi = 0; gi < WB_SELW; gi++) begin : g_lane
         logic [7:0] mem [0:(1<<DEPTH_LOG2)-1];
         logic [7:0] rd_q;
         logic       lane_we;

         assign lane_we = we_i && (|wmask_i[8*gi +: 8]);

         always_ff @(posedge clk_i) begin
            if (lane_we) begin
               mem[addr_i] <= wdata_i[8*gi +: 8];
            end
            if (re_i) begin
               rd_q <= mem[addr_i];
            end
         end

         assign rdata_o[8*gi +: 8] = rd_q;
      end
   endgenerate

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic RAM responder with programmable wait states.
// Define WB_RAM_ERR_EN to answer out-of-range addresses with err instead of aliasing.
module wb_ram_slave
   import wb_pkg::*;
#(
   parameter int          DEPTH_LOG2  = 10,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               wbs_cyc_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_we_i,
   input  logic [WB_SELW-1:0] wbs_sel_i,
   input  logic [WB_AW-1:0]   wbs_addr_i,
   input  logic [WB_DW-1:0]   wbs_dat_i,
   output logic [WB_DW-1:0]   wbs_dat_o,
   output logic               wbs_ack_o,
   output logic               wbs_err_o
);

   localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

   wb_state_t          state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               we_q, we_d;
   logic [WB_SELW-1:0] sel_q, sel_d;
   logic [WB_AW-1:0]   addr_q, addr_d;
   logic [WB_DW-1:0]   wdat_q, wdat_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic               rd_valid_q, rd_valid_d;

   logic               cur_we;
   logic [WB_SELW-1:0] cur_sel;
   logic [WB_AW-1:0]   cur_addr;
   logic [WB_DW-1:0]   cur_wdat;
   logic               in_range;
   logic               commit;
   logic               ram_we;
   logic               ram_re;
   logic [WB_DW-1:0]   ram_rdata;
   logic               unused_ok;

   // A zero-wait transfer commits straight from IDLE, so use the live bus.
   assign cur_we   = (state_q == IDLE) ? wbs_we_i   : we_q;
   assign cur_sel  = (state_q == IDLE) ? wbs_sel_i  : sel_q;
   assign cur_addr = (state_q == IDLE) ? wbs_addr_i : addr_q;
   assign cur_wdat = (state_q == IDLE) ? wbs_dat_i  : wdat_q;

`ifdef WB_RAM_ERR_EN
   assign in_range  = (cur_addr[WB_AW-1:DEPTH_LOG2+2] == BASE_ADDR[WB_AW-1:DEPTH_LOG2+2]);
   assign unused_ok = ^{cur_addr[1:0], BASE_ADDR[DEPTH_LOG2+1:0]};
`else
   assign in_range  = 1'b1;
   assign unused_ok = ^{cur_addr[1:0], cur_addr[WB_AW-1:DEPTH_LOG2+2], BASE_ADDR};
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      sel_d      = sel_q;
      addr_d     = addr_q;
      wdat_d     = wdat_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      rd_valid_d = rd_valid_q;
      commit     = 1'b0;

      case (state_q)
         IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               we_d   = wbs_we_i;
               sel_d  = wbs_sel_i;
               addr_d = wbs_addr_i;
               wdat_d = wbs_dat_i;
               if (WAIT_STATES == 0) begin
                  commit  = 1'b1;
                  state_d = RESP;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!wbs_cyc_i) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               commit  = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Read data stays visible until a write or error response replaces it with 0.
      if (commit) begin
         ack_d      = in_range;
         err_d      = !in_range;
         rd_valid_d = in_range && !cur_we;
      end
   end

   assign ram_we = commit && cur_we && in_range && !rst_i;
   assign ram_re = commit && !cur_we && in_range && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         we_q       <= 1'b0;
         sel_q      <= '0;
         addr_q     <= '0;
         wdat_q     <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         sel_q      <= sel_d;
         addr_q     <= addr_d;
         wdat_q     <= wdat_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   wb_ram_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_ram (
      .clk_i  (clk_i),
      .we_i   (ram_we),
      .re_i   (ram_re),
      .addr_i (cur_addr[DEPTH_LOG2+1:2]),
      .wmask_i(sel_to_mask(cur_sel)),
      .wdata_i(cur_wdat),
      .rdata_o(ram_rdata)
   );

   assign wbs_dat_o = rd_valid_q ? ram_rdata : '0;
   assign wbs_ack_o = ack_q;
   assign wbs_err_o = err_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Self-checking bench: three responders (0, 1 and 3 wait states) driven with
// directed and random transfers, checked against a byte-level memory model.
module tb_wb_ram_slave;

   localparam int NI    = 3;
   localparam int DEPTH = 1024;

   function automatic int ws_of(input int i);
      return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
   endfunction

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc  [NI];
   logic        stb  [NI];
   logic        we   [NI];
   logic [3:0]  sel  [NI];
   logic [31:0] addr [NI];
   logic [31:0] wdat [NI];
   logic [31:0] rdat [NI];
   logic        ack  [NI];
   logic        err  [NI];

   logic [31:0] mdl   [NI][DEPTH];
   bit          known [NI][DEPTH];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         wb_ram_slave #(
            .DEPTH_LOG2 (10),
            .WAIT_STATES(ws_of(gi)),
            .BASE_ADDR  (32'h0000_0000)
         ) u_dut (
            .clk_i     (clk),
            .rst_i     (rst),
            .wbs_cyc_i (cyc[gi]),
            .wbs_stb_i (stb[gi]),
            .wbs_we_i  (we[gi]),
            .wbs_sel_i (sel[gi]),
            .wbs_addr_i(addr[gi]),
            .wbs_dat_i (wdat[gi]),
            .wbs_dat_o (rdat[gi]),
            .wbs_ack_o (ack[gi]),
            .wbs_err_o (err[gi])
         );
      end
   endgenerate

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic bit addr_ok(input logic [31:0] a);
`ifdef WB_RAM_ERR_EN
      return a < 32'(4 * DEPTH);
`else
      return 1'b1;
`endif
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   // Issue one transfer, hold stb until a response, then drop it for a cycle.
   task automatic xfer(input int i, input bit w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output bit got_ack,
                       output bit got_err, output logic [31:0] rd, output bit quiet_after,
                       output logic [31:0] rd_after);
      @(negedge clk);
      cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; sel[i] = s; addr[i] = a; wdat[i] = d;
      lat = -1; got_ack = 1'b0; got_err = 1'b0; rd = '0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (ack[i] || err[i]) begin
            lat = k; got_ack = ack[i]; got_err = err[i]; rd = rdat[i];
            break;
         end
      end
      cyc[i] = 1'b0; stb[i] = 1'b0;
      @(posedge clk); #1;
      quiet_after = !ack[i] && !err[i];
      rd_after    = rdat[i];
   endtask

   // Transfer plus comparison against the model; returns the observed read data.
   task automatic run(input string tag, input int i, input bit w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
      int          lat;
      bit          ga, ge, quiet;
      logic [31:0] rd_after, exp_rd;
      bit          ok, chk_rd;
      int          wi;
      ok = addr_ok(a);
      wi = word_of(a);
      chk_rd = 1'b1;
      if (w || !ok) begin
         exp_rd = 32'h0;
      end else begin
         exp_rd = mdl[i][wi];
         chk_rd = known[i][wi];
      end
      xfer(i, w, s, a, d, lat, ga, ge, rd, quiet, rd_after);
      $display("%s inst%0d %s addr=%08h sel=%h wd=%08h -> lat=%0d ack=%0d err=%0d rd=%08h",
               tag, i, w ? "WR" : "RD", a, s, d, lat, ga, ge, rd);
      chk({tag, "_lat"}, 32'(lat), 32'(ws_of(i)));
      chk({tag, "_ack"}, {31'b0, ga}, {31'b0, ok});
      chk({tag, "_err"}, {31'b0, ge}, {31'b0, !ok});
      chk({tag, "_single"}, {31'b0, quiet}, 32'd1);
      if (chk_rd) begin
         chk({tag, "_rd"}, rd, exp_rd);
         chk({tag, "_hold"}, rd_after, exp_rd);
      end
      if (w && ok) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) mdl[i][wi][8*b +: 8] = d[8*b +: 8];
         end
         if (s == 4'hF) known[i][wi] = 1'b1;
      end
   endtask

   // Start a write on the 3-wait-state responder and stop it during WAIT,
   // either by dropping cyc or by asserting reset.
   task automatic interrupted_write(input string tag, input bit use_rst, input logic [31:0] a,
                                    input logic [31:0] d);
      bit quiet;
      @(negedge clk);
      cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; addr[2] = a; wdat[2] = d;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      cyc[2] = 1'b0; stb[2] = 1'b0;
      if (use_rst) begin
         rst = 1'b1;
         @(posedge clk); #1;
         chk({tag, "_ack0"}, {31'b0, ack[2]}, 32'd0);
         chk({tag, "_err0"}, {31'b0, err[2]}, 32'd0);
         chk({tag, "_dat0"}, rdat[2], 32'd0);
         @(negedge clk);
         rst = 1'b0;
      end
      quiet = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (ack[2] || err[2]) quiet = 1'b0;
      end
      $display("%s inst2 interrupted WR addr=%08h wd=%08h quiet=%0d", tag, a, d, quiet);
      chk({tag, "_noresp"}, {31'b0, quiet}, 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; sel[i] = 4'h0; addr[i] = '0; wdat[i] = '0;
         for (int j = 0; j < DEPTH; j++) begin
            mdl[i][j] = '0; known[i][j] = 1'b0;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         chk("reset_ack", {31'b0, ack[i]}, 32'd0);
         chk("reset_err", {31'b0, err[i]}, 32'd0);
         chk("reset_dat", rdat[i], 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Basic write/read with one wait state.
      run("t1_wr", 1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd);
      run("t1_rd", 1, 1'b0, 4'hF, 32'h10, 32'h0, rd);
      chk("t1_const", rd, 32'hDEADBEEF);

      // Byte-lane merge, then a write with no lanes selected.
      run("t2_wr", 1, 1'b1, 4'hF, 32'h20, 32'h11223344, rd);
      run("t2_wrl", 1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, rd);
      run("t2_rd", 1, 1'b0, 4'h0, 32'h20, 32'h0, rd);
      chk("t2_const", rd, 32'h11BB33DD);
      run("t2_wr0", 1, 1'b1, 4'h0, 32'h20, 32'h55555555, rd);
      run("t2_rd0", 1, 1'b0, 4'hF, 32'h20, 32'h0, rd);
      chk("t2_const0", rd, 32'h11BB33DD);

      // Abort by dropping cyc during WAIT.
      run("t3_wr", 2, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, rd);
      interrupted_write("t3_abort", 1'b0, 32'h40, 32'h0BADF00D);
      run("t3_rd", 2, 1'b0, 4'hF, 32'h40, 32'h0, rd);
      chk("t3_const", rd, 32'hCAFEF00D);

      // Out-of-range address: err when enabled, alias of word 0 otherwise.
      run("t4_wr", 1, 1'b1, 4'hF, 32'h0, 32'h0000A5A5, rd);
      run("t4_rd", 1, 1'b0, 4'hF, 32'h1000, 32'h0, rd);
`ifdef WB_RAM_ERR_EN
      chk("t4_const", rd, 32'h0);
`else
      chk("t4_const", rd, 32'h0000A5A5);
`endif

      // Reset during WAIT of a write.
      interrupted_write("t5_rst", 1'b1, 32'h40, 32'h12345678);
      run("t5_rd", 2, 1'b0, 4'hF, 32'h40, 32'h0, rd);
      chk("t5_const", rd, 32'hCAFEF00D);

      // Zero wait states: back-to-back reads with a one-cycle gap.
      run("t6_wr", 0, 1'b1, 4'hF, 32'h8, 32'h0F0F0F0F, rd);
      for (int k = 0; k < 4; k++) begin
         run("t6_rd", 0, 1'b0, 4'hF, 32'h8, 32'h0, rd);
      end

      // Random traffic on a small word pool, with occasional high address bits.
      for (int i = 0; i < NI; i++) begin
         for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            bit          w;
            a = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 5) == 0) a = a | (32'($urandom_range(1, 3)) << 12);
            w = ($urandom_range(0, 1) == 1) || !known[i][word_of(a)];
            run("rnd", i, w, w ? 4'($urandom_range(0, 15)) : 4'hF, a, $urandom, rd);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
